// File: rtl/fifo_sk6812_tx.sv
// SK6812 serial transmitter fed from the read port of the RGBW FIFO.
// Pops one GRBW word per LED, sends it MSB-first as NRZ pulses, then holds
// the line low for the latch period at the end of each frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line low, waiting for en with a word available
// S_BIT   | driving one bit period of the current word
// S_FETCH | one low clock between words, pops the next word
// S_LATCH | line low for the reset/latch period, frame_done on exit
module fifo_sk6812_tx #(
    parameter int DATA_SIZE = 32,
    parameter int NUM_LEDS  = 64,
    parameter int T_BIT     = 120,
    parameter int T0H       = 29,
    parameter int T1H       = 58,
    parameter int T_RESET   = 7680
) (
    input  logic                 r_clk,
    input  logic                 r_rst_n,
    input  logic                 en,
    input  logic                 r_empty,
    input  logic [DATA_SIZE-1:0] r_data,
    output logic                 r_en,
    output logic                 led_dout,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 underrun
);

    localparam int TMR_MAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int LED_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int IDX_W   = $clog2(DATA_SIZE);

    // The bit timer counts down from T_BIT-1, so "high for the first N clocks"
    // becomes "timer still at or above T_BIT-N".
    localparam logic [TMR_W-1:0] TMR_BIT  = TMR_W'(T_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_RST  = TMR_W'(T_RESET);
    localparam logic [TMR_W-1:0] HI0_TC   = TMR_W'(T_BIT - T0H);
    localparam logic [TMR_W-1:0] HI1_TC   = TMR_W'(T_BIT - T1H);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(NUM_LEDS - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DATA_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_BIT, S_FETCH, S_LATCH} state_t;

    state_t               state, state_nxt;
    logic [TMR_W-1:0]     tmr;
    logic [IDX_W-1:0]     bit_idx;
    logic [LED_W-1:0]     led_cnt;
    logic [DATA_SIZE-1:0] sh;

    // State register
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en && !r_empty) state_nxt = S_BIT;
            S_BIT:   if (tmr == '0 && bit_idx == '0)
                         state_nxt = (led_cnt == LED_LAST) ? S_LATCH : S_FETCH;
            S_FETCH: state_nxt = r_empty ? S_LATCH : S_BIT;
            S_LATCH: if (tmr == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs; r_en is held off during reset so the FIFO never pops while held
    always_comb begin
        r_en       = 1'b0;
        led_dout   = 1'b0;
        busy       = (state != S_IDLE);
        frame_done = 1'b0;
        case (state)
            S_IDLE:  r_en = r_rst_n && en && !r_empty;
            S_BIT:   led_dout = (tmr >= (sh[DATA_SIZE-1] ? HI1_TC : HI0_TC));
            S_FETCH: r_en = r_rst_n && !r_empty;
            S_LATCH: frame_done = (tmr == '0);
            default: ;
        endcase
    end

    // Datapath: shift register, bit/LED indices, shared down-timer, sticky underrun
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            tmr      <= '0;
            bit_idx  <= '0;
            led_cnt  <= '0;
            sh       <= '0;
            underrun <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && !r_empty) begin
                        sh      <= r_data;
                        bit_idx <= IDX_TOP;
                        tmr     <= TMR_BIT;
                        led_cnt <= '0;
                    end
                end
                S_BIT: begin
                    if (tmr != '0) begin
                        tmr <= tmr - TMR_ONE;
                    end else if (bit_idx != '0) begin
                        sh      <= {sh[DATA_SIZE-2:0], 1'b0};
                        bit_idx <= bit_idx - 1'b1;
                        tmr     <= TMR_BIT;
                    end else if (led_cnt == LED_LAST) begin
                        tmr <= TMR_RST;
                    end else begin
                        led_cnt <= led_cnt + 1'b1;
                    end
                end
                S_FETCH: begin
                    if (!r_empty) begin
                        sh      <= r_data;
                        bit_idx <= IDX_TOP;
                        tmr     <= TMR_BIT;
                    end else begin
                        tmr      <= TMR_RST;
                        underrun <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (tmr != '0) tmr <= tmr - TMR_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule
